buffer_write_arbiter: RTL

BUFFER_WRITE_ARBITER -- requirements
Module: buffer_write_arbiter

---
 rtl/buffer_write_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/buffer_write_arbiter.sv
// Two-requester, packet-granular round-robin arbiter for a shared buffer write port.
// Tracks per-packet length, truncation on full, idle timeout and total buffer fill.
module buffer_write_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int DEPTH   = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr_valid0,
  input  logic        wr_valid1,
  input  logic [31:0] data_in0,
  input  logic [31:0] data_in1,
  input  logic        last0,
  input  logic        last1,
  output logic        grant0,
  output logic        grant1,
  output logic        buf_wr_en,
  output logic [31:0] buf_data_in,
  output logic        pkt_done,
  output logic        pkt_src,
  output logic [14:0] pkt_len,
  output logic        pkt_err,
  output logic        buf_full,
  output logic [14:0] words_used
);

  localparam int          IW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [14:0] DEPTH_W = 15'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic            grant0_q, grant0_d, grant1_q, grant1_d;
  logic            wr_en_q, wr_en_d;
  logic [31:0]     data_q, data_d;
  logic            done_q, done_d;
  logic            src_q, src_d;
  logic [14:0]     pkt_len_q, pkt_len_d;
  logic            err_q, err_d;
  logic            full_q, full_d;
  logic [14:0]     used_q, used_d;
  logic [14:0]     len_q, len_d;
  logic            trunc_q, trunc_d;
  logic [IW-1:0]   idle_q, idle_d;

  logic            own_valid_s, own_last_s;
  logic [31:0]     own_data_s;
  logic [14:0]     len_new_s;
  logic            trunc_new_s;
  logic [IW-1:0]   idle_inc_s;

  assign own_valid_s = owner_q ? wr_valid1 : wr_valid0;
  assign own_last_s  = owner_q ? last1     : last0;
  assign own_data_s  = owner_q ? data_in1  : data_in0;
  assign idle_inc_s  = idle_q + IW'(1);

  // Next-state and output decode for the IDLE/BUSY ownership FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    grant0_d    = grant0_q;
    grant1_d    = grant1_q;
    wr_en_d     = 1'b0;
    data_d      = data_q;
    done_d      = 1'b0;
    src_d       = src_q;
    pkt_len_d   = pkt_len_q;
    err_d       = err_q;
    used_d      = used_q;
    len_d       = len_q;
    trunc_d     = trunc_q;
    idle_d      = idle_q;
    len_new_s   = len_q;
    trunc_new_s = trunc_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // rr_q names the requester holding priority on a tie
          owner_d  = (req0 && req1) ? rr_q : req1;
          state_d  = BUSY;
          grant0_d = ~owner_d;
          grant1_d = owner_d;
          len_d    = 15'd0;
          trunc_d  = 1'b0;
          idle_d   = '0;
        end else begin
          grant0_d = 1'b0;
          grant1_d = 1'b0;
        end
      end
      BUSY: begin
        if (own_valid_s) begin
          idle_d = '0;
          if (!full_q) begin
            wr_en_d   = 1'b1;
            data_d    = own_data_s;
            used_d    = used_q + 15'd1;
            len_new_s = len_q + 15'd1;
          end else begin
            trunc_new_s = 1'b1;
          end
          len_d   = len_new_s;
          trunc_d = trunc_new_s;
          if (own_last_s) begin
            state_d   = IDLE;
            grant0_d  = 1'b0;
            grant1_d  = 1'b0;
            done_d    = 1'b1;
            src_d     = owner_q;
            pkt_len_d = len_new_s;
            err_d     = trunc_new_s;
            rr_d      = ~owner_q;
          end else begin
            state_d = BUSY;
          end
        end else if ((TIMEOUT > 0) && (idle_inc_s == IW'(TIMEOUT))) begin
          state_d   = IDLE;
          grant0_d  = 1'b0;
          grant1_d  = 1'b0;
          done_d    = 1'b1;
          src_d     = owner_q;
          pkt_len_d = len_q;
          err_d     = 1'b1;
          rr_d      = ~owner_q;
        end else if (TIMEOUT > 0) begin
          idle_d = idle_inc_s;
        end else begin
          idle_d = idle_q;
        end
      end
      default: begin
        state_d  = IDLE;
        grant0_d = 1'b0;
        grant1_d = 1'b0;
      end
    endcase

    full_d = (used_d == DEPTH_W);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      data_q    <= 32'd0;
      done_q    <= 1'b0;
      src_q     <= 1'b0;
      pkt_len_q <= 15'd0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
      used_q    <= 15'd0;
      len_q     <= 15'd0;
      trunc_q   <= 1'b0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      grant0_q  <= grant0_d;
      grant1_q  <= grant1_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      done_q    <= done_d;
      src_q     <= src_d;
      pkt_len_q <= pkt_len_d;
      err_q     <= err_d;
      full_q    <= full_d;
      used_q    <= used_d;
      len_q     <= len_d;
      trunc_q   <= trunc_d;
      idle_q    <= idle_d;
    end
  end

  assign grant0      = grant0_q;
  assign grant1      = grant1_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_data_in = data_q;
  assign pkt_done    = done_q;
  assign pkt_src     = src_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_err     = err_q;
  assign buf_full    = full_q;
  assign words_used  = used_q;

endmodule
